sentinel_seq_lock: RTL

Parametrised multi-byte key-sequence authenticator for the Sentinel family. It accepts a stream of WIDTH-bit key symbols, compares each against a DEPTH-symbol stored key, and grants access only on a full-sequence match. Consecutive failures are counted, and a configurable lockout timer is enforced after MAX_FAIL failures. It sits behind the top-level input pins and drives the Sentinel status/display logic.

---
 rtl/sentinel_seq_lock.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sentinel_seq_lock.sv
// Key-sequence authenticator: WIDTH-bit symbols are matched against a
// DEPTH-symbol key, with a fail counter and a timed lockout.
module sentinel_seq_lock #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [DEPTH*WIDTH-1:0] KEY = 32'h5AC33CA5,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    localparam int FW = $clog2(MAX_FAIL + 1),
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             granted,
    output logic             locked_out,
    output logic             fail_pulse,
    output logic [FW-1:0]    fail_count,
    output logic [PW-1:0]    progress,
    output logic [1:0]       state
);

    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ARMED   = 2'b00,
        GRANTED = 2'b01,
        LOCKOUT = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  progress_q, progress_d;
    logic           flag_q, flag_d;
    logic [FW-1:0]  fail_count_q, fail_count_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           fail_pulse_q, fail_pulse_d;
    logic [WIDTH-1:0] cur_sym;
    logic           mism;
    logic           last;

    always_comb begin
        cur_sym = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (progress_q == PW'(i)) begin
                cur_sym = KEY[i*WIDTH +: WIDTH];
            end
        end
    end

    assign mism = (in_data != cur_sym);
    assign last = (progress_q == PW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARMED;
            progress_q   <= '0;
            flag_q       <= 1'b0;
            fail_count_q <= '0;
            timer_q      <= '0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            progress_q   <= progress_d;
            flag_q       <= flag_d;
            fail_count_q <= fail_count_d;
            timer_q      <= timer_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    // The verdict is only formed on the final symbol, so an early
    // mismatch is never observable before the attempt completes.
    always_comb begin
        state_d      = state_q;
        progress_d   = progress_q;
        flag_d       = flag_q;
        fail_count_d = fail_count_q;
        timer_d      = timer_q;
        fail_pulse_d = 1'b0;
        case (state_q)
            ARMED: begin
                if (clear) begin
                    progress_d = '0;
                    flag_d     = 1'b0;
                end else if (in_valid && last) begin
                    progress_d = '0;
                    flag_d     = 1'b0;
                    if (!(flag_q || mism)) begin
                        state_d      = GRANTED;
                        fail_count_d = '0;
                    end else begin
                        fail_pulse_d = 1'b1;
                        if (fail_count_q + 1'b1 == FW'(MAX_FAIL)) begin
                            state_d      = LOCKOUT;
                            fail_count_d = FW'(MAX_FAIL);
                            timer_d      = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_count_d = fail_count_q + 1'b1;
                        end
                    end
                end else if (in_valid) begin
                    flag_d     = flag_q || mism;
                    progress_d = progress_q + 1'b1;
                end
            end
            GRANTED: begin
                if (clear) begin
                    state_d    = ARMED;
                    progress_d = '0;
                    flag_d     = 1'b0;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d      = ARMED;
                    fail_count_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    assign granted    = (state_q == GRANTED);
    assign locked_out = (state_q == LOCKOUT);
    assign fail_pulse = fail_pulse_q;
    assign fail_count = fail_count_q;
    assign progress   = progress_q;
    assign state      = state_q;

endmodule
